// File: rtl/nlprg8_checker_pkg.sv
// nlprg8_checker_pkg: shared sequence function, FSM states and reset constant
package nlprg8_checker_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  localparam logic [7:0] SEQ_RESET = 8'h00;
  function automatic logic [7:0] nlprg8_f(input logic [7:0] s);
    return {s[6:3], ~(s[3] ^ s[2]) ^ (s[1] & s[0] & ~|s[7:3]), s[3] ^ s[6] ^ s[1], s[4] ^ s[5] ^ s[0], ~(s[6] ^ s[7] ^ s[3])};
  endfunction
endpackage

// File: rtl/nlprg8_next.sv
// nlprg8_next: combinational next-word function of the 8-bit nonlinear sequence
// s: current word, n: next word
module nlprg8_next
  import nlprg8_checker_pkg::*;
(
  input  logic [7:0] s,
  output logic [7:0] n
);
  assign n = nlprg8_f(s);
endmodule

// File: rtl/nlprg8_checker.sv
// nlprg8_checker: self-synchronising checker for the 8-bit nonlinear sequence
// clk/Clr: clock, async active-high reset; in_valid/in_data: received word;
// cnt_clr: clear error counters; locked/err_pulse/sync_loss: status;
// word_errs/bit_errs: saturating error counts
module nlprg8_checker
  import nlprg8_checker_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             Clr,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] word_errs,
  output logic [CNT_W-1:0] bit_errs
);
  state_t state, state_nx;
  logic [7:0] pred, f_in, f_pred;
  logic [3:0] match_cnt, miss_cnt;
  logic hit, miss_err, lose, lock_hit;
  logic [CNT_W:0] w_sum, b_sum;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p += 4'(v[i]);
    return p;
  endfunction
  nlprg8_next u_seed (.s(in_data), .n(f_in));
  nlprg8_next u_fly  (.s(pred),    .n(f_pred));
  assign hit      = in_data == pred;
  assign miss_err = in_valid && state == LOCKED && !hit;
  assign lose     = miss_err && miss_cnt + 4'd1 == 4'(LOSS_CNT);
  assign lock_hit = state == VERIFY && hit && match_cnt + 4'd1 == 4'(LOCK_CNT);
  // one extra bit catches overflow so the counters can clamp at all-ones
  assign w_sum = {1'b0, word_errs} + (CNT_W+1)'(1);
  assign b_sum = {1'b0, bit_errs} + (CNT_W+1)'(popcount(in_data ^ pred));
  always_comb begin
    state_nx = !in_valid ? state :
               state == HUNT ? VERIFY :
               state == VERIFY ? (lock_hit ? LOCKED : VERIFY) :
               (lose ? HUNT : LOCKED);
  end
  always_ff @(posedge clk or posedge Clr)
    if (Clr) state <= HUNT;
    else state <= state_nx;
  always_ff @(posedge clk or posedge Clr)
    if (Clr) begin
      pred      <= SEQ_RESET;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
      word_errs <= '0;
      bit_errs  <= '0;
    end else begin
      locked    <= state_nx == LOCKED;
      err_pulse <= miss_err;
      sync_loss <= lose;
      if (in_valid) begin
        // flywheel while locked so a corrupted word never reaches the predictor
        pred      <= state == LOCKED ? f_pred : f_in;
        match_cnt <= state == VERIFY && hit ? match_cnt + 4'd1 : '0;
        miss_cnt  <= state == LOCKED && !hit ? miss_cnt + 4'd1 : '0;
      end
      word_errs <= cnt_clr ? '0 : !miss_err ? word_errs : w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      bit_errs  <= cnt_clr ? '0 : !miss_err ? bit_errs : b_sum[CNT_W] ? '1 : b_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_nlprg8_checker.sv
// tb_nlprg8_checker: randomized and directed check of nlprg8_checker against a behavioural model
module tb_nlprg8_checker;
  localparam int LOCK = 4, LOSS = 3, W = 4, MAXC = (1 << W) - 1;
  logic clk = 0, Clr = 1, in_valid = 0, cnt_clr = 0;
  logic [7:0] in_data = 0;
  logic locked, err_pulse, sync_loss;
  logic [W-1:0] word_errs, bit_errs;
  int checks = 0, errors = 0;
  int ms, mmatch, mmiss, e_we, e_be;
  logic [7:0] mpred, g;
  logic e_err, e_loss;
  nlprg8_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(W)) dut (
    .clk(clk), .Clr(Clr), .in_valid(in_valid), .in_data(in_data), .cnt_clr(cnt_clr),
    .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss),
    .word_errs(word_errs), .bit_errs(bit_errs));
  always #5 clk = ~clk;
  function automatic logic [7:0] bf(input logic [7:0] s);
    logic [7:0] n;
    n[0] = ~(s[6] ^ s[7] ^ s[3]);
    n[1] = s[4] ^ s[5] ^ s[0];
    n[2] = s[3] ^ s[6] ^ s[1];
    n[3] = ~(s[3] ^ s[2]) ^ (s[1] & s[0] & (s[7:3] == 5'd0));
    n[7:4] = s[6:3];
    return n;
  endfunction
  function automatic int sat(input int v);
    return v > MAXC ? MAXC : v;
  endfunction
  task automatic model_reset();
    ms = 0; mmatch = 0; mmiss = 0; e_we = 0; e_be = 0; mpred = 0; e_err = 0; e_loss = 0;
  endtask
  task automatic model(input logic v, input logic [7:0] d, input logic c);
    e_err = 0; e_loss = 0;
    if (v) begin
      if (ms == 0) begin
        mpred = bf(d); mmatch = 0; ms = 1;
      end else if (ms == 1) begin
        mmatch = d == mpred ? mmatch + 1 : 0;
        mpred = bf(d);
        if (mmatch == LOCK) begin ms = 2; mmiss = 0; end
      end else begin
        if (d != mpred) begin
          e_err = 1; e_we = sat(e_we + 1); e_be = sat(e_be + $countones(d ^ mpred)); mmiss++;
          if (mmiss == LOSS) begin ms = 0; e_loss = 1; end
        end else mmiss = 0;
        mpred = bf(mpred);
      end
    end
    if (c) begin e_we = 0; e_be = 0; end
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    check("locked", 32'(locked), 32'(ms == 2));
    check("err_pulse", 32'(err_pulse), 32'(e_err));
    check("sync_loss", 32'(sync_loss), 32'(e_loss));
    check("word_errs", 32'(word_errs), 32'(e_we));
    check("bit_errs", 32'(bit_errs), 32'(e_be));
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    in_valid = v; in_data = d; cnt_clr = c;
    model(v, d, c);
    @(posedge clk);
    #1 check_all();
  endtask
  // next word from the reference generator, optionally corrupted by mask
  task automatic send(input logic [7:0] mask, input logic c);
    step(1'b1, g ^ mask, c);
    g = bf(g);
  endtask
  task automatic sync_reset();
    @(negedge clk); Clr = 1; in_valid = 0; cnt_clr = 0;
    @(negedge clk); Clr = 0;
    model_reset(); g = 8'h00;
  endtask
  initial begin
    model_reset(); g = 8'h00;
    #12 check_all();
    Clr = 0;
    // clean stream from reset seed: lock after 5th word
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    check("pre_lock", 32'(locked), 32'd0);
    send(8'h00, 0);
    check("lock_5th", 32'(locked), 32'd1);
    for (int i = 0; i < 3; i++) send(8'h00, 0);
    // single bit flip
    send(8'h01, 0);
    check("flip_we", 32'(word_errs), 32'd1);
    check("flip_be", 32'(bit_errs), 32'd1);
    for (int i = 0; i < 3; i++) send(8'h00, 0);
    // burst of 3 inverted words forces loss, then relock
    for (int i = 0; i < 3; i++) send(8'hFF, 0);
    check("burst_loss", 32'(sync_loss), 32'd1);
    for (int i = 0; i < 6; i++) send(8'h00, 0);
    // mismatch in VERIFY after 2 matches
    sync_reset();
    for (int i = 0; i < 3; i++) send(8'h00, 0);
    send(8'h40, 0);
    for (int i = 0; i < 6; i++) send(8'h00, 0);
    // idle gaps alternate with words
    sync_reset();
    for (int i = 0; i < 12; i++) begin
      send(8'h00, 0);
      step(1'b0, 8'($urandom), 1'b0);
    end
    // randomized stream with errors, gaps and clears
    sync_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'($urandom_range(0, 15) == 0));
      else send($urandom_range(0, 7) == 0 ? 8'($urandom_range(1, 255)) : 8'h00, 1'($urandom_range(0, 15) == 0));
    end
    // saturation without loss, then clear colliding with an error
    sync_reset();
    for (int i = 0; i < 5; i++) send(8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      send(8'h03, 0);
      send(8'h00, 0);
    end
    check("sat_we", 32'(word_errs), 32'd15);
    send(8'h10, 1);
    check("clr_wins", 32'(word_errs), 32'd0);
    send(8'h22, 0);
    // asynchronous Clr between edges
    @(posedge clk);
    #2 Clr = 1;
    model_reset();
    #1 check_all();
    @(negedge clk); Clr = 0;
    for (int i = 0; i < 7; i++) send(8'h00, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nlprg8_checker.md
# nlprg8_checker

Receive-side checker for the 8-bit nonlinear pseudo-random sequence produced by the team's 8-bit generator. It sits directly downstream of the generator or the link it drives, and consumes one 8-bit word per valid cycle. It self-synchronises by seeding a local predictor from the incoming stream, then flywheels and counts word and bit errors. It also reports lock and loss-of-sync.

## Interface
- LOCK_CNT, 4: consecutive correct predictions needed to declare lock (1..15).
- LOSS_CNT, 3: consecutive mismatched words while locked that force loss of sync (1..15).
- CNT_W, 16: width of the error counters.
- clk  in  1  rising-edge clock.
- Clr  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data is a sequence word this cycle.
- in_data  in  8  received word.
- cnt_clr  in  1  synchronous clear of both error counters; lock state is unaffected.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched word in LOCKED.
- sync_loss  out  1  one-cycle pulse on LOCKED to HUNT.
- word_errs  out  CNT_W  saturating count of mismatched words.
- bit_errs  out  CNT_W  saturating sum of differing bits.

## Operation
- Next-state function f(s) for s[7:0]:
  - n0 = ~(s6^s7^s3).
  - n1 = s4^s5^s0.
  - n2 = s3^s6^s1.
  - n3 = ~(s3^s2) ^ (s1 & s0 & ~s7 & ~s6 & ~s5 & ~s4 & ~s3).
  - n4..n7 = s3..s6.
- FSM states: HUNT, VERIFY, LOCKED. Reset state is HUNT. All registers and outputs reset to 0.
- HUNT, on in_valid: pred <= f(in_data), match_cnt <= 0, go to VERIFY.
- VERIFY, on in_valid:
  - Match (in_data == pred): pred <= f(in_data), match_cnt++. When the match count reaches LOCK_CNT, go to LOCKED and set locked.
  - Mismatch: pred <= f(in_data) (reseed), match_cnt <= 0, stay in VERIFY.
- LOCKED, on in_valid: pred <= f(pred) (flywheel; a received error never corrupts the predictor).
  - Match: miss_cnt <= 0.
  - Mismatch: err_pulse, word_errs += 1, bit_errs += popcount(in_data ^ pred), miss_cnt++.
  - When miss_cnt reaches LOSS_CNT: go to HUNT, locked <= 0, sync_loss pulse. The triggering word is still counted.
- in_valid low: no state, predictor or counter change; pulses low.
- Counters saturate at all-ones and only change in LOCKED.
- cnt_clr and an increment in the same cycle: cnt_clr wins, and the counter becomes 0.

## Timing
- All outputs are registered and update on the edge that samples in_valid. They are visible in the cycle after the word.
- Lock latency: the seed word plus LOCK_CNT matching words. locked rises after the edge sampling the (LOCK_CNT+1)th valid word.
- err_pulse and sync_loss are high for exactly one cycle, with no merging across back-to-back events.
- Clr asserted mid-operation: the block immediately returns to HUNT with all outputs 0, independent of clk. The first valid word after Clr deasserts is treated as a seed.
- Full throughput: one word per cycle, no backpressure.

## Structure
- Shared package holds:
  - the f() function, shared with the generator's model;
  - the state enum {HUNT, VERIFY, LOCKED};
  - the sequence reset constant 8'h00.
- Natural sub-module: nlprg8_next, the combinational f() used for both reseed and flywheel, instantiated twice or muxed.
- The popcount is a local function.

## Test plan
- Clean stream: after Clr, send the reset-seeded sequence 0x00, 0x09, 0x16, 0x27, … → locked = 1 after the 5th valid word; counters stay 0.
- Single bit flip while locked: replace one word with its value ^ 0x01 → one err_pulse, word_errs = 1, bit_errs = 1, locked stays 1, and the following correct words match.
- Burst of 3 wrong words (each ^ 0xFF) while locked → word_errs = 3, bit_errs = 24, sync_loss pulse on the 3rd, locked = 0; a clean stream then relocks after 5 words.
- Mismatch during VERIFY after 2 matches → no counter change; lock requires 4 further consecutive matches from the reseed.
- in_valid gaps (alternating 1/0) on a clean stream → same lock point in valid words; nothing advances on idle cycles.
- Saturation and clear (CNT_W = 4): force 20 errors without loss (interleave matches) → word_errs = 15; cnt_clr together with an error → 0. Async Clr mid-burst → outputs 0 immediately.
